// File: rtl/riscv_pkg.sv
// riscv_pkg: shared writeback encodings and default data width
package riscv_pkg;
   localparam int XLEN_DEFAULT = 32;
   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10,
      WB_IMM  = 2'b11
   } wb_sel_e;
   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LD  = 3'b011,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101,
      F3_LWU = 3'b110
   } load_f3_e;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: aligns, extracts and extends load data; flags illegal offsets
module load_formatter
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            misaligned
);
   localparam bit IS64 = (XLEN == 64);
   logic [63:0]     sh;
   logic [XLEN-1:0] lw;
   // widen to 64 bits first so offsets past XLEN shift in zeros and LD needs no special case
   assign sh = 64'(rdata) >> {offset, 3'b000};
   assign lw = XLEN'($signed(sh[31:0]));
   // undefined or width-unsupported encodings fall back to LW data and fault
   always_comb begin
      data       = lw;
      misaligned = 1'b1;
      case (funct3)
         F3_LB:  begin data = XLEN'($signed(sh[7:0]));  misaligned = 1'b0;               end
         F3_LBU: begin data = XLEN'(sh[7:0]);           misaligned = 1'b0;               end
         F3_LH:  begin data = XLEN'($signed(sh[15:0])); misaligned = offset[0];          end
         F3_LHU: begin data = XLEN'(sh[15:0]);          misaligned = offset[0];          end
         F3_LW:  begin data = lw;                       misaligned = |offset[1:0];       end
         F3_LWU: begin data = IS64 ? XLEN'(sh[31:0]) : lw; misaligned = IS64 ? |offset[1:0] : 1'b1; end
         F3_LD:  begin data = IS64 ? XLEN'(sh) : lw;    misaligned = IS64 ? |offset : 1'b1;   end
         default: ;
      endcase
   end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB pipeline register, result select and retire counter
module writeback_unit
   import riscv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_reg_write,
   input  logic [1:0]        in_wb_sel,
   input  logic [2:0]        in_funct3,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [XLEN-1:0]   in_alu_result,
   input  logic [XLEN-1:0]   in_mem_rdata,
   input  logic [XLEN-1:0]   in_pc_plus4,
   input  logic [XLEN-1:0]   in_imm,
   output logic              rd_we,
   output logic [REG_AW-1:0] rd_addr,
   output logic [XLEN-1:0]   rd_data,
   output logic              wb_valid,
   output logic              load_misaligned,
   output logic [CNT_W-1:0]  instret
);
   logic              valid;
   logic              reg_write;
   logic [1:0]        wb_sel;
   logic [2:0]        funct3;
   logic [REG_AW-1:0] rd;
   logic [XLEN-1:0]   alu_result;
   logic [XLEN-1:0]   mem_rdata;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   imm;
   logic [XLEN-1:0]   load_data;
   logic              load_fault;
   // pipeline register: reset beats flush, flush beats stall
   always_ff @(posedge clk) begin
      if (reset) begin
         valid      <= 1'b0;
         reg_write  <= 1'b0;
         wb_sel     <= '0;
         funct3     <= '0;
         rd         <= '0;
         alu_result <= '0;
         mem_rdata  <= '0;
         pc_plus4   <= '0;
         imm        <= '0;
      end else if (!stall) begin
         valid      <= in_valid & ~flush;
         reg_write  <= in_reg_write;
         wb_sel     <= in_wb_sel;
         funct3     <= in_funct3;
         rd         <= in_rd;
         alu_result <= in_alu_result;
         mem_rdata  <= in_mem_rdata;
         pc_plus4   <= in_pc_plus4;
         imm        <= in_imm;
      end else if (flush) begin
         valid      <= 1'b0;
      end
   end
   load_formatter #(.XLEN(XLEN)) u_fmt (
      .rdata      (mem_rdata),
      .offset     (alu_result[2:0]),
      .funct3     (funct3),
      .data       (load_data),
      .misaligned (load_fault)
   );
   assign wb_valid        = valid & ~stall;
   assign load_misaligned = (wb_sel == WB_LOAD) & load_fault;
   assign rd_we           = wb_valid & reg_write & (rd != '0) & ~load_misaligned;
   assign rd_addr         = rd;
   assign rd_data         = (wb_sel == WB_ALU)  ? alu_result :
                            (wb_sel == WB_LOAD) ? load_data  :
                            (wb_sel == WB_PC4)  ? pc_plus4   : imm;
   // retire counter wraps silently from all-ones to zero
   always_ff @(posedge clk) begin
      if (reset) instret <= '0;
      else if (wb_valid) instret <= instret + CNT_W'(1);
   end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table-driven scoreboard bench plus stall/flush/reset/wrap sequences
module tb_writeback_unit;
   logic        clk = 1'b0;
   logic        reset, in_valid, stall, flush, in_reg_write;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
   logic        rd_we, wb_valid, load_misaligned;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [63:0] instret;
   logic        w_we, w_valid, w_mis;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [3:0]  instret_w;

   typedef struct {
      logic        valid, rw, flush;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu, mem, pc4, imm;
      logic        we;
      logic [31:0] data;
      logic        wbv, mis;
   } vec_t;

   localparam logic [31:0] M = 32'h80FF7F01;
   localparam logic [31:0] P = 32'h0000_0104;
   localparam logic [31:0] I = 32'hFFFF_F000;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] exp_ret = 0;
   vec_t        tbl[$];
   vec_t        sb[$];
   vec_t        e;

   writeback_unit u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_rd(in_rd),
      .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4),
      .in_imm(in_imm), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
      .wb_valid(wb_valid), .load_misaligned(load_misaligned), .instret(instret)
   );

   writeback_unit #(.CNT_W(4)) u_wrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
      .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_rd(in_rd),
      .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4),
      .in_imm(in_imm), .rd_we(w_we), .rd_addr(w_addr), .rd_data(w_data),
      .wb_valid(w_valid), .load_misaligned(w_mis), .instret(instret_w)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic valid, rw, fl, input logic [1:0] sel, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic we, input logic [31:0] data, input logic wbv, mis);
      vec_t v;
      v.valid = valid; v.rw = rw; v.flush = fl; v.sel = sel; v.f3 = f3; v.rd = rd;
      v.alu = alu; v.mem = M; v.pc4 = P; v.imm = I;
      v.we = we; v.data = data; v.wbv = wbv; v.mis = mis;
      return v;
   endfunction

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      n_cmp++;
      if (a !== x) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
   endtask

   task automatic apply(input vec_t v);
      in_valid = v.valid; in_reg_write = v.rw; flush = v.flush; in_wb_sel = v.sel;
      in_funct3 = v.f3; in_rd = v.rd; in_alu_result = v.alu; in_mem_rdata = v.mem;
      in_pc_plus4 = v.pc4; in_imm = v.imm;
   endtask

   task automatic idle();
      apply(mk(0, 0, 0, 2'd0, 3'd0, 5'd0, 32'h0, 0, 32'h0, 0, 0));
      stall = 1'b0;
   endtask

   task automatic chk_zero(input string n);
      chk({n, ".we"}, rd_we, 0);
      chk({n, ".addr"}, rd_addr, 0);
      chk({n, ".data"}, rd_data, 0);
      chk({n, ".wbv"}, wb_valid, 0);
      chk({n, ".mis"}, load_misaligned, 0);
      chk({n, ".instret"}, instret, 0);
      chk({n, ".instret_w"}, instret_w, 0);
   endtask

   initial begin
      vec_t x;
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_zero("reset");

      tbl.push_back(mk(1, 1, 0, 2'd0, 3'd0, 5'd5,  32'h1234, 1, 32'h1234,     1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd0, 5'd7,  32'h1003, 1, 32'hFFFFFF80, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd4, 5'd7,  32'h1003, 1, 32'h00000080, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd1, 5'd7,  32'h1001, 0, 32'hFFFFFF7F, 1, 1));
      tbl.push_back(mk(1, 1, 0, 2'd0, 3'd0, 5'd0,  32'hDEAD, 0, 32'h0000DEAD, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd5, 5'd9,  32'h0002, 1, 32'h000080FF, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd1, 5'd9,  32'h0002, 1, 32'hFFFF80FF, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd2, 5'd10, 32'h0100, 1, 32'h80FF7F01, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd2, 5'd10, 32'h0102, 0, 32'h000080FF, 1, 1));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd7, 5'd10, 32'h0100, 0, 32'h80FF7F01, 1, 1));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd3, 5'd10, 32'h0100, 0, 32'h80FF7F01, 1, 1));
      tbl.push_back(mk(1, 1, 0, 2'd2, 3'd0, 5'd1,  32'h0000, 1, P,            1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd3, 3'd0, 5'd2,  32'h0000, 1, I,            1, 0));
      tbl.push_back(mk(0, 1, 0, 2'd0, 3'd0, 5'd6,  32'h0055, 0, 32'h00000055, 0, 0));
      tbl.push_back(mk(1, 0, 0, 2'd0, 3'd0, 5'd6,  32'h0066, 0, 32'h00000066, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd0, 5'd3,  32'h0000, 1, 32'h00000001, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd0, 5'd3,  32'h0001, 1, 32'h0000007F, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd0, 5'd3,  32'h0002, 1, 32'hFFFFFFFF, 1, 0));
      tbl.push_back(mk(1, 1, 0, 2'd1, 3'd5, 5'd4,  32'h0003, 0, 32'h00000080, 1, 1));
      tbl.push_back(mk(1, 1, 0, 2'd0, 3'd1, 5'd8,  32'h1235, 1, 32'h00001235, 1, 0));
      tbl.push_back(mk(1, 1, 1, 2'd0, 3'd0, 5'd8,  32'h0077, 0, 32'h00000077, 0, 0));

      foreach (tbl[i]) begin
         apply(tbl[i]);
         stall = 1'b0;
         sb.push_back(tbl[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("we[%0d]", i), rd_we, e.we);
         chk($sformatf("addr[%0d]", i), rd_addr, e.rd);
         chk($sformatf("data[%0d]", i), rd_data, e.data);
         chk($sformatf("wbv[%0d]", i), wb_valid, e.wbv);
         chk($sformatf("mis[%0d]", i), load_misaligned, e.mis);
         chk($sformatf("instret[%0d]", i), instret, exp_ret);
         chk($sformatf("instret_w[%0d]", i), instret_w, 64'(exp_ret[3:0]));
         if (e.wbv) exp_ret++;
      end
      idle();
      @(posedge clk);
      #1 chk("drain.instret", instret, exp_ret);

      // three stall cycles, then exactly one retire
      x = mk(1, 1, 0, 2'd0, 3'd0, 5'd3, 32'hA5A5, 1, 32'hA5A5, 1, 0);
      apply(x);
      @(posedge clk);
      #1 stall = 1'b1; in_valid = 1'b0;
      #1 chk("stall0.wbv", wb_valid, 0);
      chk("stall0.we", rd_we, 0);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1 chk($sformatf("stall%0d.wbv", k), wb_valid, 0);
         chk($sformatf("stall%0d.data", k), rd_data, 32'hA5A5);
         chk($sformatf("stall%0d.instret", k), instret, exp_ret);
      end
      stall = 1'b0;
      #1 chk("unstall.wbv", wb_valid, 1);
      chk("unstall.we", rd_we, 1);
      chk("unstall.data", rd_data, 32'hA5A5);
      @(posedge clk);
      exp_ret++;
      #1 chk("unstall.instret", instret, exp_ret);
      chk("unstall.next_wbv", wb_valid, 0);

      // stall and flush together drop the held instruction
      apply(mk(1, 1, 0, 2'd0, 3'd0, 5'd4, 32'h0BAD, 1, 32'h0BAD, 1, 0));
      @(posedge clk);
      #1 stall = 1'b1; flush = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1 stall = 1'b0; flush = 1'b0;
      #1 chk("sflush.wbv", wb_valid, 0);
      chk("sflush.we", rd_we, 0);
      @(posedge clk);
      #1 chk("sflush.instret", instret, exp_ret);

      // reset while a misaligned load is held by stall
      apply(mk(1, 1, 0, 2'd1, 3'd1, 5'd12, 32'h0001, 0, 32'h0, 1, 1));
      @(posedge clk);
      #1 stall = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      idle();
      exp_ret = 0;
      #1 chk_zero("midstall");
      @(posedge clk);
      #1 chk("midstall.after_wbv", wb_valid, 0);
      chk("midstall.after_instret", instret, 0);

      // sixteen retirements wrap the 4-bit counter
      for (int k = 0; k < 16; k++) begin
         apply(mk(1, 1, 0, 2'd0, 3'd0, 5'd1, 32'(k), 1, 32'(k), 1, 0));
         @(posedge clk);
         #1;
      end
      idle();
      @(posedge clk);
      #1 chk("wrap.instret", instret, 16);
      chk("wrap.instret_w", instret_w, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
